// File: rtl/tdm_demux_if.sv
// Serial-link and parallel-output bundle for tdm_demux.
// master drives the serial line and observes outputs; slave is the demux side.
interface tdm_demux_if #(
  parameter int NUM_CH   = 4,
  parameter int CH_WIDTH = 8
);
  // valid_in qualifies data_in and frame_sync; there is no backpressure, so every
  // valid bit is consumed in the cycle it is presented. Outputs are 1-cycle pulses.
  logic                         data_in;
  logic                         valid_in;
  logic                         frame_sync;
  logic [NUM_CH*CH_WIDTH-1:0]   ch_data;
  logic [NUM_CH-1:0]            ch_valid;
  logic                         frame_done;
  logic                         sync_err;
  logic                         parity_err;

  modport master (
    output data_in, valid_in, frame_sync,
    input  ch_data, ch_valid, frame_done, sync_err, parity_err
  );

  modport slave (
    input  data_in, valid_in, frame_sync,
    output ch_data, ch_valid, frame_done, sync_err, parity_err
  );
endinterface

// File: rtl/tdm_demux.sv
// TDM serial receiver: tracks slot position, deserialises MSB-first channels into slices.
// Optional frame parity check enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
  parameter int NUM_CH   = 4,
  parameter int CH_WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  tdm_demux_if.slave    bus,
  output logic [1:0]    state_o
);
  localparam int BW = $clog2(CH_WIDTH);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [BW-1:0] BIT_LAST = BW'(CH_WIDTH - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

  localparam logic [1:0] S_HUNT = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_END  = 2'd2;
`ifdef TDM_DEMUX_PARITY_EN
  localparam logic [1:0] S_PAR  = 2'd3;
`endif

  logic [1:0]                 state_q, state_d;
  logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]              ch_cnt_q, ch_cnt_d;
  // Only CH_WIDTH-1 bits are stored; the final bit of a slot goes straight to its slice.
  logic [CH_WIDTH-2:0]        sr_q, sr_d;
  logic [NUM_CH*CH_WIDTH-1:0] data_q, data_d;
  logic [NUM_CH-1:0]          ch_valid_q, ch_valid_d;
  logic                       frame_done_q, frame_done_d;
  logic                       sync_err_q, sync_err_d;
  logic [CH_WIDTH-1:0]        word;
  logic                       start;
`ifdef TDM_DEMUX_PARITY_EN
  logic                       par_q, par_d;
  logic                       parity_err_q, parity_err_d;
`endif

  assign word = {sr_q, bus.data_in};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    sr_d         = sr_q;
    data_d       = data_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    start        = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    if (bus.valid_in) begin
      case (state_q)
        S_HUNT: start = bus.frame_sync;
        S_RECV: begin
          if (bus.frame_sync) begin
            // Mid-frame sync: drop the partial slot and restart on this bit.
            sync_err_d = 1'b1;
            start      = 1'b1;
          end else begin
            sr_d = word[CH_WIDTH-2:0];
`ifdef TDM_DEMUX_PARITY_EN
            par_d = par_q ^ bus.data_in;
`endif
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              for (int k = 0; k < NUM_CH; k++) begin
                if (ch_cnt_q == CW'(k)) begin
                  data_d[k*CH_WIDTH +: CH_WIDTH] = word;
                  ch_valid_d[k] = 1'b1;
                end
              end
              if (ch_cnt_q == CH_LAST) begin
                ch_cnt_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
                state_d = S_PAR;
`else
                state_d      = S_END;
                frame_done_d = 1'b1;
`endif
              end else begin
                ch_cnt_d = ch_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_END: begin
          if (bus.frame_sync) begin
            start = 1'b1;
          end else begin
            sync_err_d = 1'b1;
            state_d    = S_HUNT;
          end
        end
`ifdef TDM_DEMUX_PARITY_EN
        S_PAR: begin
          if (bus.frame_sync) begin
            sync_err_d = 1'b1;
            start      = 1'b1;
          end else begin
            frame_done_d = 1'b1;
            parity_err_d = par_q ^ bus.data_in;
            state_d      = S_END;
          end
        end
`endif
        default: state_d = S_HUNT;
      endcase
    end
    if (start) begin
      state_d   = S_RECV;
      bit_cnt_d = BW'(1);
      ch_cnt_d  = '0;
      sr_d      = '0;
      sr_d[0]   = bus.data_in;
`ifdef TDM_DEMUX_PARITY_EN
      par_d     = bus.data_in;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_HUNT;
      bit_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      sr_q         <= '0;
      data_q       <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      sr_q         <= sr_d;
      data_q       <= data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.ch_data    = data_q;
  assign bus.ch_valid   = ch_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign state_o = state_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (4 x 8-bit): scoreboard of expected output pulses,
// each stamped with the cycle it must appear in, drained by an independent monitor.
module tb_tdm_demux;
  localparam int NUM_CH   = 4;
  localparam int CH_WIDTH = 8;
  localparam int RW       = 32 + NUM_CH + 3 + NUM_CH*CH_WIDTH;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] state_o;

  tdm_demux_if #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH)) bus ();

  tdm_demux #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_v, exp_v;
  logic [31:0]   exp_data = '0;
  int            n_cmp = 0;
  int            n_fail = 0;
`ifdef TDM_DEMUX_PARITY_EN
  bit            par_flip = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] cv, input logic fd, input logic se, input logic pe);
    exp_q.push_back({32'(cyc + 1), cv, fd, se, pe, exp_data});
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge
  task automatic drive(input logic d, input logic v, input logic s);
    bus.data_in    = d;
    bus.valid_in   = v;
    bus.frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] frame, input int gap,
                            input bit err_first, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int ch = i / 8;
      int b  = 7 - (i % 8);
      if (i == 0 && err_first) push_exp(4'b0000, 1'b0, 1'b1, 1'b0);
      if (b == 0) begin
        exp_data[ch*8 +: 8] = frame[ch*8 +: 8];
`ifdef TDM_DEMUX_PARITY_EN
        push_exp(4'b0001 << ch, 1'b0, 1'b0, 1'b0);
`else
        push_exp(4'b0001 << ch, ch == 3, 1'b0, 1'b0);
`endif
      end
      drive(frame[ch*8 + b], 1'b1, i == 0);
      for (int g = 0; g < gap; g++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (nbits == 32) begin
      push_exp(4'b0000, 1'b1, 1'b0, par_flip);
      drive((^frame) ^ par_flip, 1'b1, 1'b0);
    end
`endif
  endtask

  task automatic send_unsynced(input logic [31:0] frame);
    push_exp(4'b0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) drive(frame[31 - i], 1'b1, 1'b0);
  endtask

  // Monitor: every active output cycle must match the next expected event
  always @(negedge clk) begin
    if (|bus.ch_valid || bus.frame_done || bus.sync_err || bus.parity_err) begin
      got_v = {32'(cyc), bus.ch_valid, bus.frame_done, bus.sync_err, bus.parity_err, bus.ch_data};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got cyc=%0d ev=%b data=%h expected none",
                 cyc, got_v[RW-33:32], got_v[31:0]);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL output_event: got cyc=%0d ev=%b data=%h expected cyc=%0d ev=%b data=%h",
                   got_v[RW-1:RW-32], got_v[RW-33:32], got_v[31:0],
                   exp_v[RW-1:RW-32], exp_v[RW-33:32], exp_v[31:0]);
        end
      end
    end
  end

  initial begin
    bus.data_in = 1'b0; bus.valid_in = 1'b0; bus.frame_sync = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("reset_outputs", 64'({bus.ch_valid, bus.frame_done, bus.sync_err, bus.parity_err, bus.ch_data}), 64'd0);
    check("reset_state", 64'(state_o), 64'd0);

    // Bits without frame_sync are ignored
    for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    check("nosync_data", 64'(bus.ch_data), 64'd0);
    check("nosync_state", 64'(state_o), 64'd0);

    // Frame A5,3C,FF,00 back to back
    send_frame(32'h00FF3CA5, 0, 1'b0, 32);
    drive(1'b0, 1'b0, 1'b0);
    check("frame_a", 64'(bus.ch_data), 64'h00FF3CA5);

    // Same frame, valid_in low on alternate cycles (frame_sync asserted when invalid)
    send_frame(32'h00FF3CA5, 1, 1'b0, 32);
    drive(1'b0, 1'b0, 1'b0);
    check("frame_a_gapped", 64'(bus.ch_data), 64'h00FF3CA5);

    // ch0 complete, 3 bits of ch1, then sync on ch1 bit 3
    send_frame(32'h00FF3CA5, 0, 1'b0, 11);
    check("partial_hold", 64'(bus.ch_data), 64'h00FF3CA5);
    send_frame(32'h44332211, 0, 1'b1, 32);
    drive(1'b0, 1'b0, 1'b0);
    check("midsync_frame", 64'(bus.ch_data), 64'h44332211);

    // Next frame with no frame_sync: sync_err, back to HUNT, data held
    send_unsynced(32'h55667788);
    check("unsynced_hold", 64'(bus.ch_data), 64'h44332211);
    check("unsynced_state", 64'(state_o), 64'd0);
    send_frame(32'h04030201, 2, 1'b0, 32);
    drive(1'b0, 1'b0, 1'b0);
    check("resync_frame", 64'(bus.ch_data), 64'h04030201);

    // Reset during ch2
    send_frame(32'hEFBEADDE, 0, 1'b0, 20);
    rst_i = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    rst_i = 1'b0;
    exp_data = '0;
    check("midreset_outputs", 64'({bus.ch_valid, bus.frame_done, bus.sync_err, bus.parity_err, bus.ch_data}), 64'd0);
    check("midreset_state", 64'(state_o), 64'd0);
    send_frame(32'hCAFE1234, 0, 1'b0, 32);
    drive(1'b0, 1'b0, 1'b0);
    check("post_reset_frame", 64'(bus.ch_data), 64'hCAFE1234);

`ifdef TDM_DEMUX_PARITY_EN
    par_flip = 1'b1;
    send_frame(32'h0F0F0F0F, 0, 1'b0, 32);
    par_flip = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    check("parity_frame", 64'(bus.ch_data), 64'h0F0F0F0F);
`endif

    repeat (4) drive(1'b0, 1'b0, 1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
